// File: rtl/data_memory_pkg.sv
// Shared definitions for the data memory stage: access sizes, funct3 encodings,
// the byte-enable type and the load lane extract/extend helper.
package data_memory_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10,
    MEM_D = 2'b11
  } mem_size_e;

  typedef logic [7:0] byte_en_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  function automatic mem_size_e size_of(input logic [2:0] f3);
    return mem_size_e'(f3[1:0]);
  endfunction

  // Offset bits that must be zero for a naturally aligned access of this size.
  function automatic logic [2:0] align_mask(input mem_size_e size);
    case (size)
      MEM_B:   return 3'b000;
      MEM_H:   return 3'b001;
      MEM_W:   return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [63:0] load_extend(input logic [2:0]  f3,
                                              input logic [63:0] word,
                                              input logic [2:0]  off);
    logic [63:0] lane;
    lane = word >> {off, 3'b000};
    case (f3)
      LB:      return {{56{lane[7]}}, lane[7:0]};
      LH:      return {{48{lane[15]}}, lane[15:0]};
      LW:      return {{32{lane[31]}}, lane[31:0]};
      LD:      return lane;
      LBU:     return {56'd0, lane[7:0]};
      LHU:     return {48'd0, lane[15:0]};
      LWU:     return {32'd0, lane[31:0]};
      default: return 64'd0;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Load/store bus between the ALU-side datapath (master) and the data memory (slave).
interface data_memory_if;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [63:0] rdata;
  logic        misaligned;

  modport master (
    output addr, wdata, mem_read, mem_write, funct3,
    input  rdata, misaligned
  );

  modport slave (
    input  addr, wdata, mem_read, mem_write, funct3,
    output rdata, misaligned
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte-enables and shifted write data, plus
// extraction and sign/zero extension of the addressed lane for loads.
module dmem_lane_align
  import data_memory_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [2:0]  offset_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rword_i,
  output byte_en_t    byte_en_o,
  output logic [63:0] wdata_o,
  output logic [63:0] load_o
);

  mem_size_e size;
  byte_en_t  size_mask;

  assign size = size_of(funct3_i);

  // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    size_mask = 8'h00;
    case (size)
      MEM_B:   size_mask = 8'h01;
      MEM_H:   size_mask = 8'h03;
      MEM_W:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  assign byte_en_o = size_mask << offset_i;
  assign wdata_o   = wdata_i << {offset_i, 3'b000};
  assign load_o    = load_extend(funct3_i, rword_i, offset_i);

endmodule

// File: rtl/data_memory.sv
// RV64 data memory: DEPTH_WORDS x 64-bit flop array, combinational loads, clocked stores.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned accesses instead of force-aligning them.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int DEPTH_WORDS = 512
) (
  input  logic          clk,
  input  logic          rst,
  data_memory_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [63:0]      mem_q [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic [2:0]       raw_off;
  logic [2:0]       off;
  logic [2:0]       mask;
  logic             misaligned_w;
  logic             store_en;
  logic [63:0]      rword;
  logic [63:0]      wdata_sh;
  logic [63:0]      load_val;
  logic [63:0]      wr_word_d;
  byte_en_t         byte_en;
  logic             unused_addr_hi;

  // Upper address bits are dropped so accesses wrap modulo the array size.
  assign idx            = bus.addr[3 +: IDX_W];
  assign raw_off        = bus.addr[2:0];
  assign unused_addr_hi = ^bus.addr[63:3+IDX_W];
  assign mask           = align_mask(size_of(bus.funct3));

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misaligned_w   = (bus.mem_read | bus.mem_write) & (|(raw_off & mask));
  assign off            = raw_off;
`else
  assign misaligned_w   = 1'b0;
  assign off            = raw_off & ~mask;
`endif
  assign bus.misaligned = misaligned_w;

  assign rword = mem_q[idx];

  dmem_lane_align u_lane (
    .funct3_i  (bus.funct3),
    .offset_i  (off),
    .wdata_i   (bus.wdata),
    .rword_i   (rword),
    .byte_en_o (byte_en),
    .wdata_o   (wdata_sh),
    .load_o    (load_val)
  );

  assign bus.rdata = (bus.mem_read && !misaligned_w) ? load_val : 64'd0;

  // Unsigned-size encodings (funct3[2]=1) are not valid stores.
  assign store_en = bus.mem_write & ~bus.funct3[2] & ~misaligned_w;

  always_comb begin
    wr_word_d = rword;
    for (int b = 0; b < 8; b++) begin
      if (byte_en[b]) wr_word_d[8*b +: 8] = wdata_sh[8*b +: 8];
    end
  end

  // NOTE: the whole array is cleared on reset because loads must read 0 right after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (store_en) begin
      mem_q[idx] <= wr_word_d;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory; expected values are queued when a
// step is driven and popped when the DUT output is sampled.
module tb_data_memory;
  import data_memory_pkg::*;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     checks = 0;
  int     errors = 0;
  exp_t   sb_q[$];

  data_memory_if bus ();

  data_memory #(.DEPTH_WORDS(512)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.funct3    = f3;
    bus.addr      = a;
    bus.wdata     = wd;
  endtask

  task automatic expect_val(input string tag, input logic [63:0] v);
    sb_q.push_back('{tag: tag, val: v});
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h with no expected entry", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic store(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
    @(negedge clk);
    drive(1'b0, 1'b1, f3, a, wd);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, LB, 64'd0, 64'd0);
  endtask

  task automatic load(input string tag, input logic [2:0] f3, input logic [63:0] a,
                      input logic [63:0] exp);
    @(negedge clk);
    drive(1'b1, 1'b0, f3, a, 64'd0);
    expect_val(tag, exp);
    #1;
    check(bus.rdata);
  endtask

  initial begin
    drive(1'b0, 1'b0, LB, 64'd0, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state and reset-wins-over-store
    load("reset_ld_0x10", LD, 64'h10, 64'd0);
    load("reset_ld_top", LD, 64'hFF8, 64'd0);
    store(SW, 64'h10, 64'hDEADBEEF);
    load("pre_reset_ld", LD, 64'h10, 64'h0000_0000_DEAD_BEEF);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b1, SD, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, LB, 64'd0, 64'd0);
    load("post_reset_ld", LD, 64'h10, 64'd0);

    // Load extraction and extension
    store(SD, 64'h08, 64'h0123_4567_89AB_CDEF);
    load("lb_0x08", LB, 64'h08, 64'hFFFF_FFFF_FFFF_FFEF);
    load("lbu_0x0f", LBU, 64'h0F, 64'h0000_0000_0000_0001);
    load("lh_0x0a", LH, 64'h0A, 64'hFFFF_FFFF_FFFF_89AB);
    load("lwu_0x0c", LWU, 64'h0C, 64'h0000_0000_0123_4567);
    load("lw_0x08", LW, 64'h08, 64'hFFFF_FFFF_89AB_CDEF);
    load("lhu_0x0e", LHU, 64'h0E, 64'h0000_0000_0000_0123);
    load("ld_0x08", LD, 64'h08, 64'h0123_4567_89AB_CDEF);

    // mem_read low, undefined load funct3, illegal store funct3
    @(negedge clk);
    drive(1'b0, 1'b0, LD, 64'h08, 64'd0);
    expect_val("no_read_zero", 64'd0);
    #1;
    check(bus.rdata);
    load("funct3_111_zero", 3'b111, 64'h08, 64'd0);
    store(3'b100, 64'h08, 64'd0);
    load("illegal_store_ignored", LD, 64'h08, 64'h0123_4567_89AB_CDEF);

    // Byte enables: only the addressed lanes change
    store(SD, 64'h20, 64'd0);
    store(SB, 64'h23, 64'h5555_5555_5555_55AA);
    load("sb_lane_0x23", LD, 64'h20, 64'h0000_0000_AA00_0000);
    store(SH, 64'h26, 64'h1234_5678_9ABC_BEEF);
    load("sh_lane_0x26", LD, 64'h20, 64'hBEEF_0000_AA00_0000);

    // Same-cycle read and write returns old data
    store(SD, 64'h30, 64'd5);
    @(negedge clk);
    drive(1'b1, 1'b1, LD, 64'h30, 64'd9);
    expect_val("rw_same_cycle_old", 64'd5);
    #1;
    check(bus.rdata);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, LB, 64'd0, 64'd0);
    load("rw_next_cycle_new", LD, 64'h30, 64'd9);

    // Address wrap modulo DEPTH_WORDS*8
    store(SD, 64'h1000, 64'd7);
    load("wrap_ld_0x0", LD, 64'h0, 64'd7);

    // Misaligned word store at 0x42
    @(negedge clk);
    drive(1'b0, 1'b1, SW, 64'h42, 64'h1122_3344);
`ifdef DMEM_MISALIGN_TRAP_EN
    expect_val("misaligned_store_flag", 64'd1);
`else
    expect_val("misaligned_store_flag", 64'd0);
`endif
    #1;
    check({63'd0, bus.misaligned});
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, LB, 64'd0, 64'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
    load("misalign_mem_unchanged", LW, 64'h40, 64'd0);
    load("misalign_load_zero", LW, 64'h42, 64'd0);
    expect_val("misaligned_load_flag", 64'd1);
    check({63'd0, bus.misaligned});
`else
    load("forced_align_lw_0x40", LW, 64'h40, 64'h0000_0000_1122_3344);
    load("forced_align_lw_0x42", LW, 64'h42, 64'h0000_0000_1122_3344);
    expect_val("misaligned_tied_low", 64'd0);
    check({63'd0, bus.misaligned});
`endif

    @(negedge clk);
    drive(1'b0, 1'b0, LB, 64'd0, 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
